ps2_link_sequencer: RTL and testbench

Bit-level PS/2 line sequencer that sits between the PS/2 MMIO byte-FIFO controller and the open-drain PS/2 clock/data pins. It receives device-to-host frames and runs the host-to-device transmit handshake (inhibit, request-to-send, shift, acknowledge). It also tracks device presence. The FIFO controller above it sees only byte-wide valid/ready strobes and a `connected` flag.

---
 rtl/ps2_link_sequencer.sv | 272 +++++++++++++++++++++++++++
 tb/tb_ps2_link_sequencer.sv | 334 +++++++++++++++++++++++++++++++++
 2 files changed

// File: rtl/ps2_link_sequencer.sv
// PS/2 bit-level line sequencer: conditions the raw pins, receives device frames
// and runs the host-to-device transmit handshake for the byte-FIFO controller.
module ps2_link_sequencer #(
  parameter int FILTER_LEN       = 8,
  parameter int INHIBIT_CYCLES   = 9000,
  parameter int BIT_TIMEOUT      = 18000,
  parameter int REPLY_TIMEOUT    = 1350000,
  parameter int STUCK_LOW_CYCLES = 9000000
) (
  input  logic       main_clk,
  input  logic       reset,
  input  logic       ps2_clk_in,
  input  logic       ps2_data_in,
  output logic       ps2_clk_drive_low,
  output logic       ps2_data_drive_low,
  output logic [7:0] rx_byte,
  output logic       rx_valid,
  output logic       rx_error,
  input  logic [7:0] tx_byte,
  input  logic       tx_request,
  output logic       tx_ready,
  output logic       tx_done,
  output logic       tx_fail,
  output logic       connected
);

  localparam int MAX_AB = (INHIBIT_CYCLES > BIT_TIMEOUT) ? INHIBIT_CYCLES : BIT_TIMEOUT;
  localparam int MAX_T  = (MAX_AB > REPLY_TIMEOUT) ? MAX_AB : REPLY_TIMEOUT;
  localparam int TW     = $clog2(MAX_T + 1);
  localparam int FW     = (FILTER_LEN > 1) ? $clog2(FILTER_LEN) : 1;
  localparam int SW     = (STUCK_LOW_CYCLES > 1) ? $clog2(STUCK_LOW_CYCLES) : 1;

  typedef enum logic [2:0] {
    IDLE, RX, TX_INHIBIT, TX_RTS, TX_SHIFT, TX_ACK, TX_RELEASE
  } state_t;

  logic [1:0]    r_clkSync, r_dataSync;
  logic [FW-1:0] r_clkRun, r_dataRun;
  logic          r_clkFilt, r_dataFilt, r_fe;

  state_t        r_state, w_stateNext;
  logic [TW-1:0] r_timer, w_timerNext;
  logic [3:0]    r_bitCnt, w_bitCntNext;
  logic [10:0]   r_shift, w_shiftNext;
  logic [7:0]    r_rxByte, w_rxByteNext;
  logic          r_rxValid, w_rxValidNext;
  logic          r_rxError, w_rxErrorNext;
  logic          r_txDone, w_txDoneNext;
  logic          r_txFail, w_txFailNext;
  logic          r_connected, w_connNext;
  logic          r_clkDrive, w_clkDriveNext;
  logic          r_dataDrive, w_dataDriveNext;
  logic          r_acked, w_ackedNext;
  logic [SW-1:0] r_stuckCnt;

  logic [10:0]   w_rxFrame;
  logic          w_rxGood, w_timerZero, w_stuck;

  // A filtered level only flips after FILTER_LEN agreeing synchronized samples;
  // fe is registered together with the clock flip so both appear in the same cycle.
  always_ff @(posedge main_clk) begin
    if (reset) begin
      r_clkSync  <= 2'b11;
      r_dataSync <= 2'b11;
      r_clkRun   <= '0;
      r_dataRun  <= '0;
      r_clkFilt  <= 1'b1;
      r_dataFilt <= 1'b1;
      r_fe       <= 1'b0;
    end else begin
      r_clkSync  <= {r_clkSync[0], ps2_clk_in};
      r_dataSync <= {r_dataSync[0], ps2_data_in};
      r_fe       <= 1'b0;
      if (r_clkSync[1] == r_clkFilt) begin
        r_clkRun <= '0;
      end else if (r_clkRun == FW'(FILTER_LEN - 1)) begin
        r_clkRun  <= '0;
        r_clkFilt <= r_clkSync[1];
        r_fe      <= r_clkFilt;
      end else begin
        r_clkRun <= r_clkRun + 1'b1;
      end
      if (r_dataSync[1] == r_dataFilt) begin
        r_dataRun <= '0;
      end else if (r_dataRun == FW'(FILTER_LEN - 1)) begin
        r_dataRun  <= '0;
        r_dataFilt <= r_dataSync[1];
      end else begin
        r_dataRun <= r_dataRun + 1'b1;
      end
    end
  end

  // Our own inhibit pulls the clock low, so it must not count as a stuck line.
  always_ff @(posedge main_clk) begin
    if (reset || r_clkFilt || r_state == TX_INHIBIT) begin
      r_stuckCnt <= '0;
    end else if (r_stuckCnt != SW'(STUCK_LOW_CYCLES - 1)) begin
      r_stuckCnt <= r_stuckCnt + 1'b1;
    end
  end

  assign w_stuck     = ~r_clkFilt && (r_state != TX_INHIBIT) &&
                       (r_stuckCnt == SW'(STUCK_LOW_CYCLES - 1));
  assign w_timerZero = (r_timer == '0);
  assign w_rxFrame   = {r_dataFilt, r_shift[10:1]};
  assign w_rxGood    = ~w_rxFrame[0] & w_rxFrame[10] & (w_rxFrame[9] == ~^w_rxFrame[8:1]);

  always_ff @(posedge main_clk) begin
    if (reset) begin
      r_state     <= IDLE;
      r_timer     <= '0;
      r_bitCnt    <= '0;
      r_shift     <= '0;
      r_rxByte    <= '0;
      r_rxValid   <= 1'b0;
      r_rxError   <= 1'b0;
      r_txDone    <= 1'b0;
      r_txFail    <= 1'b0;
      r_connected <= 1'b0;
      r_clkDrive  <= 1'b0;
      r_dataDrive <= 1'b0;
      r_acked     <= 1'b0;
    end else begin
      r_state     <= w_stateNext;
      r_timer     <= w_timerNext;
      r_bitCnt    <= w_bitCntNext;
      r_shift     <= w_shiftNext;
      r_rxByte    <= w_rxByteNext;
      r_rxValid   <= w_rxValidNext;
      r_rxError   <= w_rxErrorNext;
      r_txDone    <= w_txDoneNext;
      r_txFail    <= w_txFailNext;
      r_connected <= w_connNext;
      r_clkDrive  <= w_clkDriveNext;
      r_dataDrive <= w_dataDriveNext;
      r_acked     <= w_ackedNext;
    end
  end

  // The start bit is captured by the fe that leaves IDLE, so RX counts the ten bits after it.
  always_comb begin
    w_stateNext     = r_state;
    w_timerNext     = w_timerZero ? r_timer : r_timer - 1'b1;
    w_bitCntNext    = r_bitCnt;
    w_shiftNext     = r_shift;
    w_rxByteNext    = r_rxByte;
    w_rxValidNext   = 1'b0;
    w_rxErrorNext   = 1'b0;
    w_txDoneNext    = 1'b0;
    w_txFailNext    = 1'b0;
    w_connNext      = r_connected;
    w_clkDriveNext  = r_clkDrive;
    w_dataDriveNext = r_dataDrive;
    w_ackedNext     = r_acked;
    case (r_state)
      IDLE: begin
        if (r_fe) begin
          w_stateNext  = RX;
          w_bitCntNext = '0;
          w_shiftNext  = w_rxFrame;
          w_timerNext  = TW'(BIT_TIMEOUT - 1);
        end else if (tx_request) begin
          if (!r_connected) begin
            w_txFailNext = 1'b1;
          end else begin
            w_shiftNext    = {2'b00, ~^tx_byte, tx_byte};
            w_ackedNext    = 1'b0;
            w_clkDriveNext = 1'b1;
            w_stateNext    = TX_INHIBIT;
            w_timerNext    = TW'(INHIBIT_CYCLES - 1);
          end
        end
      end
      RX: begin
        if (r_fe) begin
          w_shiftNext = w_rxFrame;
          w_timerNext = TW'(BIT_TIMEOUT - 1);
          if (r_bitCnt == 4'd9) begin
            w_stateNext = IDLE;
            if (w_rxGood) begin
              w_rxByteNext  = w_rxFrame[8:1];
              w_rxValidNext = 1'b1;
              w_connNext    = 1'b1;
            end else begin
              w_rxErrorNext = 1'b1;
            end
          end else begin
            w_bitCntNext = r_bitCnt + 4'd1;
          end
        end else if (w_timerZero) begin
          w_rxErrorNext = 1'b1;
          w_stateNext   = IDLE;
        end
      end
      TX_INHIBIT: begin
        if (w_timerZero) begin
          w_clkDriveNext  = 1'b0;
          w_dataDriveNext = 1'b1;
          w_stateNext     = TX_RTS;
          w_timerNext     = TW'(REPLY_TIMEOUT - 1);
        end
      end
      TX_RTS: begin
        if (r_fe) begin
          w_dataDriveNext = ~r_shift[0];
          w_bitCntNext    = 4'd1;
          w_stateNext     = TX_SHIFT;
          w_timerNext     = TW'(BIT_TIMEOUT - 1);
        end else if (w_timerZero) begin
          w_dataDriveNext = 1'b0;
          w_clkDriveNext  = 1'b0;
          w_txFailNext    = 1'b1;
          w_connNext      = 1'b0;
          w_stateNext     = IDLE;
        end
      end
      TX_SHIFT: begin
        if (r_fe) begin
          w_timerNext = TW'(BIT_TIMEOUT - 1);
          if (r_bitCnt == 4'd9) begin
            w_dataDriveNext = 1'b0;
            w_stateNext     = TX_ACK;
          end else begin
            w_dataDriveNext = ~r_shift[r_bitCnt];
            w_bitCntNext    = r_bitCnt + 4'd1;
          end
        end else if (w_timerZero) begin
          w_dataDriveNext = 1'b0;
          w_clkDriveNext  = 1'b0;
          w_txFailNext    = 1'b1;
          w_stateNext     = IDLE;
        end
      end
      TX_ACK: begin
        if (r_fe) begin
          w_stateNext = TX_RELEASE;
          if (!r_dataFilt) begin
            w_ackedNext = 1'b1;
            w_connNext  = 1'b1;
          end else begin
            w_txFailNext = 1'b1;
          end
        end else if (w_timerZero) begin
          w_dataDriveNext = 1'b0;
          w_clkDriveNext  = 1'b0;
          w_txFailNext    = 1'b1;
          w_stateNext     = IDLE;
        end
      end
      TX_RELEASE: begin
        if (r_clkFilt && r_dataFilt) begin
          w_txDoneNext = r_acked;
          w_stateNext  = IDLE;
        end
      end
      default: w_stateNext = IDLE;
    endcase
    if (w_stuck) w_connNext = 1'b0;
  end

  assign tx_ready           = (r_state == IDLE) && !r_fe;
  assign ps2_clk_drive_low  = r_clkDrive;
  assign ps2_data_drive_low = r_dataDrive;
  assign rx_byte            = r_rxByte;
  assign rx_valid           = r_rxValid;
  assign rx_error           = r_rxError;
  assign tx_done            = r_txDone;
  assign tx_fail            = r_txFail;
  assign connected          = r_connected;

endmodule

// File: tb/tb_ps2_link_sequencer.sv
// Bench for ps2_link_sequencer: an open-drain device model drives the pins while a
// scoreboard matches every rx/tx pulse against events predicted from frame rules.
module tb_ps2_link_sequencer;

  localparam int FL  = 4;
  localparam int INH = 60;
  localparam int BTO = 300;
  localparam int RTO = 700;
  localparam int STK = 2000;
  localparam int H   = 25;

  localparam logic [1:0] K_RXV = 2'd0;
  localparam logic [1:0] K_RXE = 2'd1;
  localparam logic [1:0] K_TXD = 2'd2;
  localparam logic [1:0] K_TXF = 2'd3;

  typedef struct packed {
    logic [1:0] kind;
    logic [7:0] data;
  } ev_t;

  logic       main_clk = 1'b0;
  logic       reset = 1'b1;
  logic       devClk = 1'b1;
  logic       devData = 1'b1;
  logic       pinClk, pinData;
  logic       clkDrive, dataDrive;
  logic [7:0] rx_byte;
  logic       rx_valid, rx_error;
  logic [7:0] txByte = 8'h00;
  logic       txRequest = 1'b0;
  logic       tx_ready, tx_done, tx_fail, connected;

  int  checks = 0;
  int  errors = 0;
  ev_t expQ[$];

  logic       connModel = 1'b0;
  logic [7:0] lastByte = 8'h00;
  int         inhRun = 0;
  int         lastInh = 0;
  logic       anyDrive = 1'b0;

  assign pinClk  = devClk & ~clkDrive;
  assign pinData = devData & ~dataDrive;

  always #5 main_clk = ~main_clk;

  ps2_link_sequencer #(
    .FILTER_LEN(FL), .INHIBIT_CYCLES(INH), .BIT_TIMEOUT(BTO),
    .REPLY_TIMEOUT(RTO), .STUCK_LOW_CYCLES(STK)
  ) dut (
    .main_clk(main_clk), .reset(reset),
    .ps2_clk_in(pinClk), .ps2_data_in(pinData),
    .ps2_clk_drive_low(clkDrive), .ps2_data_drive_low(dataDrive),
    .rx_byte(rx_byte), .rx_valid(rx_valid), .rx_error(rx_error),
    .tx_byte(txByte), .tx_request(txRequest), .tx_ready(tx_ready),
    .tx_done(tx_done), .tx_fail(tx_fail), .connected(connected)
  );

  task automatic checkOutput(input string name, input logic [31:0] actual, input logic [31:0] expected);
    checks++;
    if (actual !== expected) begin
      errors++;
      $display("[TB] FAIL %s: got 0x%0h, required 0x%0h", name, actual, expected);
    end
  endtask

  task automatic expectEvent(input logic [1:0] k, input logic [7:0] d);
    ev_t e;
    e.kind = k;
    e.data = d;
    expQ.push_back(e);
  endtask

  task automatic waitCycles(input int n);
    repeat (n) @(negedge main_clk);
  endtask

  // Scoreboard monitor: every output pulse consumes the oldest predicted event.
  logic [3:0] pulseVec;
  logic [1:0] actKind;
  ev_t        popped;
  always @(negedge main_clk) begin
    pulseVec = {tx_fail, tx_done, rx_error, rx_valid};
    if (pulseVec != 4'b0000) begin
      checks++;
      actKind = rx_valid ? K_RXV : rx_error ? K_RXE : tx_done ? K_TXD : K_TXF;
      if ($countones(pulseVec) != 1) begin
        errors++;
        $display("[TB] FAIL pulse_onehot: got %b, required a single pulse", pulseVec);
      end else if (expQ.size() == 0) begin
        errors++;
        $display("[TB] FAIL unexpected_pulse: got kind %0d, required no pulse", actKind);
      end else begin
        popped = expQ.pop_front();
        if (popped.kind != actKind) begin
          errors++;
          $display("[TB] FAIL pulse_kind: got kind %0d, required kind %0d", actKind, popped.kind);
        end else if (actKind == K_RXV || actKind == K_RXE) begin
          checks++;
          if (rx_byte !== popped.data) begin
            errors++;
            $display("[TB] FAIL rx_byte: got 0x%0h, required 0x%0h", rx_byte, popped.data);
          end
        end
      end
    end
  end

  always @(negedge main_clk) begin
    if (clkDrive || dataDrive) anyDrive = 1'b1;
    if (clkDrive === 1'b1) begin
      inhRun++;
    end else if (inhRun != 0) begin
      lastInh = inhRun;
      inhRun  = 0;
    end
  end

  task automatic sendFrame(input logic [7:0] b, input logic par, input logic st, input logic sp);
    logic [10:0] bits;
    bits = {sp, par, b, st};
    for (int i = 0; i < 11; i++) begin
      devData = bits[i];
      waitCycles(H);
      devClk = 1'b0;
      waitCycles(H);
      devClk = 1'b1;
    end
    devData = 1'b1;
  endtask

  // corrupt: 1 flips parity, 2 sets the start bit, 3 clears the stop bit.
  task automatic rxFrame(input logic [7:0] b, input int corrupt);
    logic par, st, sp, good;
    par = ($countones(b) % 2) == 0;
    st  = 1'b0;
    sp  = 1'b1;
    if (corrupt == 1) par = ~par;
    if (corrupt == 2) st = 1'b1;
    if (corrupt == 3) sp = 1'b0;
    good = !st && sp && ((($countones(b) + int'(par)) % 2) == 1);
    if (good) begin
      expectEvent(K_RXV, b);
      lastByte  = b;
      connModel = 1'b1;
    end else begin
      expectEvent(K_RXE, lastByte);
    end
    sendFrame(b, par, st, sp);
    waitCycles(FL + 8);
    checkOutput("connected_after_rx", connected, connModel);
    waitCycles(30);
  endtask

  task automatic issueRequest(input logic [7:0] b);
    logic accepted;
    accepted  = 1'b0;
    txByte    = b;
    txRequest = 1'b1;
    for (int n = 0; n < 4000 && !accepted; n++) begin
      if (tx_ready) accepted = 1'b1;
      @(negedge main_clk);
    end
    txRequest = 1'b0;
    if (!accepted) begin
      checks++;
      errors++;
      $display("[TB] FAIL accept_timeout: got no acceptance, required one");
    end
  endtask

  task automatic devRespond(input logic [7:0] b, input logic present, input logic ack, input int abortAt);
    logic       seen;
    logic [9:0] got;
    seen = 1'b0;
    got  = '0;
    for (int n = 0; n < INH + 50 && !seen; n++) begin
      if (!clkDrive && dataDrive) seen = 1'b1;
      else @(negedge main_clk);
    end
    checkOutput("rts_seen", seen, 1'b1);
    if (!seen) return;
    waitCycles(2);
    checkOutput("inhibit_len", lastInh, INH);
    if (!present) begin
      waitCycles(RTO + 20);
      checkOutput("reply_timeout_release", {clkDrive, dataDrive}, 2'b00);
      checkOutput("reply_timeout_conn", connected, 1'b0);
      return;
    end
    waitCycles(H);
    for (int k = 0; k < 10; k++) begin
      devClk = 1'b0;
      waitCycles(H);
      if (k == abortAt) begin
        devClk = 1'b1;
        return;
      end
      got[k] = pinData;
      devClk = 1'b1;
      waitCycles(H);
    end
    checkOutput("tx_data_bits", got[7:0], b);
    checkOutput("tx_parity_bit", got[8], ($countones(b) % 2) == 0);
    checkOutput("tx_stop_bit", got[9], 1'b1);
    devData = ~ack;
    waitCycles(H);
    devClk = 1'b0;
    waitCycles(H);
    devClk = 1'b1;
    waitCycles(H);
    devData = 1'b1;
    waitCycles(20);
    checkOutput("connected_after_tx", connected, connModel);
  endtask

  task automatic txTransaction(input logic [7:0] b, input logic present, input logic ack, input int abortAt);
    if (!connModel) begin
      expectEvent(K_TXF, 8'h00);
      anyDrive = 1'b0;
      issueRequest(b);
      checkOutput("nc_fail_next_cycle", tx_fail, 1'b1);
      waitCycles(30);
      checkOutput("nc_pins_idle", anyDrive, 1'b0);
      return;
    end
    if (abortAt < 0) begin
      if (!present) begin
        expectEvent(K_TXF, 8'h00);
        connModel = 1'b0;
      end else if (ack) begin
        expectEvent(K_TXD, 8'h00);
      end else begin
        expectEvent(K_TXF, 8'h00);
      end
    end
    issueRequest(b);
    checkOutput("inhibit_after_accept", clkDrive, 1'b1);
    devRespond(b, present, ack, abortAt);
    if (abortAt < 0) waitCycles(30);
  endtask

  task automatic applyStimulus(input int iterations);
    logic [7:0] b;
    int         op, corrupt;
    for (int it = 0; it < iterations; it++) begin
      b  = 8'($urandom);
      op = int'($urandom_range(0, 2));
      if (op < 2) begin
        corrupt = int'($urandom_range(0, 5));
        rxFrame(b, (corrupt > 3) ? 0 : corrupt);
      end else begin
        txTransaction(b, 1'b1, $urandom_range(0, 4) != 0, -1);
      end
    end
  endtask

  initial begin
    #800000;
    $display("[TB] FAIL watchdog: got no finish, required completion within budget");
    $fatal(1, "[TB] watchdog expired");
  end

  initial begin
    waitCycles(5);
    reset = 1'b0;
    checkOutput("reset_rx_byte", rx_byte, 8'h00);
    checkOutput("reset_connected", connected, 1'b0);
    checkOutput("reset_drives", {clkDrive, dataDrive}, 2'b00);
    checkOutput("reset_pulses", {rx_valid, rx_error, tx_done, tx_fail}, 4'b0000);
    checkOutput("reset_tx_ready", tx_ready, 1'b1);
    waitCycles(20);

    txTransaction(8'h12, 1'b1, 1'b1, -1);
    rxFrame(8'hAA, 0);
    // 0x1C has three ones, so its correct odd parity is 0; send the inverted bit.
    rxFrame(8'h1C, 1);
    txTransaction(8'hFF, 1'b1, 1'b1, -1);
    txTransaction(8'h55, 1'b0, 1'b1, -1);
    rxFrame(8'h3C, 0);

    expectEvent(K_RXV, 8'h81);
    lastByte = 8'h81;
    expectEvent(K_TXD, 8'h00);
    fork
      sendFrame(8'h81, 1'b1, 1'b0, 1'b1);
      begin
        waitCycles(H);
        waitCycles(1 + FL);
        checkOutput("ready_before_fe", tx_ready, 1'b1);
        waitCycles(1);
        checkOutput("ready_low_on_fe", tx_ready, 1'b0);
        txByte    = 8'h6B;
        txRequest = 1'b1;
        issueRequest(8'h6B);
        checkOutput("late_accept_inhibit", clkDrive, 1'b1);
        devRespond(8'h6B, 1'b1, 1'b1, -1);
      end
    join
    waitCycles(30);

    txTransaction(8'h5A, 1'b1, 1'b1, 4);
    reset = 1'b1;
    waitCycles(1);
    checkOutput("reset_mid_release", {clkDrive, dataDrive}, 2'b00);
    waitCycles(2);
    reset     = 1'b0;
    connModel = 1'b0;
    lastByte  = 8'h00;
    checkOutput("reset_mid_conn", connected, 1'b0);
    checkOutput("reset_mid_rx_byte", rx_byte, 8'h00);
    waitCycles(40);
    rxFrame(8'hFA, 0);
    txTransaction(8'hED, 1'b1, 1'b1, -1);

    expectEvent(K_RXE, lastByte);
    connModel = 1'b0;
    devClk = 1'b0;
    waitCycles(STK + 50);
    checkOutput("stuck_low_conn", connected, 1'b0);
    devClk = 1'b1;
    waitCycles(50);

    applyStimulus(14);

    waitCycles(100);
    checkOutput("queue_drained", expQ.size(), 0);
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
